// File: rtl/servo_pwm.sv
// servo_pwm: framed servo PWM generator with one-deep command buffer and tick-paced position slewing
module servo_pwm #(
  parameter int FRAME_CYCLES = 2000000,
  parameter int MIN_PULSE    = 100000,
  parameter int STEP_CYCLES  = 392,
  parameter int RESET_POS    = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic [7:0] cmd_pos,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       pwm,
  output logic       frame_start,
  output logic [7:0] cur_pos,
  output logic       at_target
);
  localparam logic [20:0] LAST    = 21'(FRAME_CYCLES - 1);
  localparam logic [20:0] W_RST   = 21'(MIN_PULSE + RESET_POS * STEP_CYCLES);
  localparam logic [7:0]  POS_RST = 8'(RESET_POS);
  logic [20:0] cnt_q, cnt_d, w_q, w_d;
  logic [7:0]  pend_q, pend_d, target_q, target_d, pos_q, pos_d;
  logic        pwm_q, pwm_d, fs_q, fs_d, ready_q, ready_d, pend_v_q, pend_v_d, sclk_q;
  logic        wrap, tick, accept;
  // next-state: frame timing, width latch at frame end, command hand-off and slewing toward the pre-update target
  always_comb begin
    wrap     = cnt_q == LAST;
    cnt_d    = wrap ? '0 : cnt_q + 21'd1;
    w_d      = wrap ? 21'(MIN_PULSE + int'(pos_q) * STEP_CYCLES) : w_q;
    pwm_d    = cnt_q < w_q;
    fs_d     = cnt_q == '0;
    accept   = cmd_valid & ready_q;
    pend_d   = accept ? cmd_pos : pend_q;
    pend_v_d = accept | (pend_v_q & ~wrap);
    target_d = (wrap & pend_v_q) ? pend_q : target_q;
    ready_d  = ~pend_v_d;
    tick     = sclk_in & ~sclk_q;
    pos_d    = (~tick | (pos_q == target_q)) ? pos_q : (pos_q < target_q) ? pos_q + 8'd1 : pos_q - 8'd1;
  end
  // state registers; reset parks the servo mid-travel and holds the command port closed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      w_q      <= W_RST;
      pwm_q    <= 1'b0;
      fs_q     <= 1'b0;
      ready_q  <= 1'b0;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
      target_q <= POS_RST;
      pos_q    <= POS_RST;
      sclk_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      pwm_q    <= pwm_d;
      fs_q     <= fs_d;
      ready_q  <= ready_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      target_q <= target_d;
      pos_q    <= pos_d;
      sclk_q   <= sclk_in;
    end
  end
  assign cmd_ready   = ready_q;
  assign pwm         = pwm_q;
  assign frame_start = fs_q;
  assign cur_pos     = pos_q;
  assign at_target   = pos_q == target_q;
endmodule

// File: tb/tb_servo_pwm.sv
// tb_servo_pwm: table-driven, directed and random checks of servo_pwm against a frame-level reference model
module tb_servo_pwm;
  localparam int F = 1000, MIN = 100, STEP = 3, RP = 128;
  logic clk, rst, sclk_in, cmd_valid, cmd_ready, pwm, frame_start, at_target;
  logic [7:0] cmd_pos, cur_pos;
  int n_chk = 0, n_fail = 0;
  int m_k, m_w, m_pos, m_tgt, m_pend, w;
  bit m_pend_v, m_ready, m_sclk, m_pwm, m_fs;
  typedef struct { logic [7:0] pos; int width; } vec_t;
  vec_t tbl[5];

  servo_pwm #(.FRAME_CYCLES(F), .MIN_PULSE(MIN), .STEP_CYCLES(STEP), .RESET_POS(RP)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .cmd_pos(cmd_pos), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .pwm(pwm), .frame_start(frame_start), .cur_pos(cur_pos), .at_target(at_target));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_w = MIN + RP * STEP; m_pos = RP; m_tgt = RP;
    m_pend_v = 0; m_ready = 0; m_sclk = 0; m_pwm = 0; m_fs = 0;
  endtask

  // one clk edge of the behavioural servo: frame position is edges-since-release modulo F
  task automatic model_step(input bit v, input int p, input bit s);
    int c = m_k % F;
    int old_pos = m_pos;
    m_pwm = c < m_w;
    m_fs = c == 0;
    if (s && !m_sclk && m_pos != m_tgt) m_pos = m_pos + ((m_pos < m_tgt) ? 1 : -1);
    if (c == F - 1) begin
      m_w = MIN + old_pos * STEP;
      if (m_pend_v) begin m_tgt = m_pend; m_pend_v = 0; end
    end
    if (v && m_ready) begin m_pend = p; m_pend_v = 1; end
    m_ready = !m_pend_v;
    m_sclk = s;
    m_k++;
  endtask

  task automatic cyc(input logic v, input logic [7:0] p, input logic s);
    cmd_valid = v; cmd_pos = p; sclk_in = s;
    @(posedge clk);
    model_step(v, int'(p), s);
    @(negedge clk);
    chk("pwm", pwm, m_pwm);
    chk("frame_start", frame_start, m_fs);
    chk("cmd_ready", cmd_ready, m_ready);
    chk("cur_pos", cur_pos, m_pos);
    chk("at_target", at_target, m_pos == m_tgt);
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_pwm"}, pwm, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_ready"}, cmd_ready, 0);
    chk({tag, "_pos"}, cur_pos, RP);
    chk({tag, "_at_target"}, at_target, 1);
  endtask

  task automatic do_reset();
    cmd_valid = 0; sclk_in = 0; cmd_pos = 0;
    #2 rst = 1;
    #1 rst_checks("rst_async");
    @(posedge clk);
    @(negedge clk);
    rst_checks("rst_hold");
    rst = 0;
    model_reset();
  endtask

  task automatic measure(output int wm);
    int n = 0;
    while (!frame_start && n < 2 * F) begin cyc(0, 0, 0); n++; end
    chk("fs_seen", frame_start, 1);
    wm = int'(pwm);
    for (int i = 1; i < F; i++) begin cyc(0, 0, 0); wm += int'(pwm); end
    cyc(0, 0, 0);
    chk("fs_period", frame_start, 1);
  endtask

  task automatic wait_transfer();
    int n = 0;
    while (m_pend_v && n < 2 * F) begin cyc(0, 0, 0); n++; end
    chk("transfer_done", cmd_ready, 1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin cyc(0, 0, 1); cyc(0, 0, 0); end
  endtask

  initial begin
    int n, p;
    tbl[0] = '{8'd255, 865};
    tbl[1] = '{8'd0,   100};
    tbl[2] = '{8'd1,   103};
    tbl[3] = '{8'd128, 484};
    tbl[4] = '{8'd200, 700};
    rst = 1; cmd_valid = 0; sclk_in = 0; cmd_pos = 0;
    @(negedge clk);
    do_reset();
    cyc(0, 0, 0);
    chk("first_ready", cmd_ready, 1);
    chk("first_pwm", pwm, 1);
    chk("first_fs", frame_start, 1);
    measure(w);
    chk("reset_width", w, 484);
    chk("reset_pos", cur_pos, 128);
    chk("reset_at_target", at_target, 1);
    // command, slew to target, then confirm the loaded pulse width
    for (int i = 0; i < 5; i++) begin
      cyc(1, tbl[i].pos, 0);
      chk("accept_ready_low", cmd_ready, 0);
      wait_transfer();
      ticks(260);
      chk("tbl_pos", cur_pos, tbl[i].pos);
      chk("tbl_at_target", at_target, 1);
      measure(w);
      chk("tbl_width", w, tbl[i].width);
    end
    // second command held while pending is full; first must still take effect
    cyc(1, 50, 0);
    n = 0;
    while (m_pend_v && n < 2 * F) begin cyc(1, 60, 0); n++; end
    cyc(1, 60, 0);
    cyc(0, 0, 0);
    chk("second_pending", cmd_ready, 0);
    ticks(1);
    chk("first_cmd_step", cur_pos, 199);
    wait_transfer();
    ticks(200);
    chk("second_cmd_pos", cur_pos, 60);
    // tick landing on the frame boundary uses the old target
    cyc(1, 62, 0);
    n = 0;
    while (m_k % F != F - 1 && n < 2 * F) begin cyc(0, 0, 0); n++; end
    cyc(0, 0, 1);
    chk("coincide_no_step", cur_pos, 60);
    chk("coincide_at_target", at_target, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("after_coincide_step", cur_pos, 61);
    for (int i = 0; i < 50; i++) cyc(0, 0, 1);
    chk("held_high", cur_pos, 61);
    for (int i = 0; i < 50; i++) cyc(0, 0, 0);
    chk("held_low", cur_pos, 61);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    chk("slow_rise", cur_pos, 62);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    chk("fall_no_step", cur_pos, 62);
    // randomized traffic against the model
    for (int i = 0; i < 15000; i++)
      cyc(logic'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom));
    // reset in the middle of a 200-position pulse
    n = 0;
    while (!cmd_ready && n < 2 * F) begin cyc(0, 0, 0); n++; end
    cyc(1, 200, 0);
    wait_transfer();
    ticks(260);
    chk("pre_rst_pos", cur_pos, 200);
    n = 0;
    while (!frame_start && n < 2 * F) begin cyc(0, 0, 0); n++; end
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);
    chk("pre_rst_pwm", pwm, 1);
    do_reset();
    measure(w);
    chk("post_rst_width", w, 484);
    chk("post_rst_pos", cur_pos, 128);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
